// File: rtl/sfr_master.sv
// sfr_master: queued SFR bus initiator for write, read, read-modify-write and poll commands
module sfr_master #(
  parameter int FIFO_DEPTH = 4,
  parameter int POLL_MAX   = 1024,
  parameter int POLL_GAP   = 3
) (
  input  logic        clk,
  input  logic        nreset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  req_op,
  input  logic [7:0]  req_addr,
  input  logic [15:0] req_data,
  input  logic [15:0] req_mask,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [15:0] rsp_data,
  output logic        rsp_err,
  output logic        sel,
  output logic [7:0]  addr,
  output logic        r,
  output logic [1:0]  w,
  output logic [15:0] dwrite,
  input  logic [15:0] sfr_data
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(POLL_MAX + 1);
  localparam int GW = POLL_GAP > 1 ? $clog2(POLL_GAP) : 1;
  localparam logic [1:0] OP_WR = 2'b00, OP_RD = 2'b01, OP_RMW = 2'b10, OP_POLL = 2'b11;
  typedef struct packed {
    logic [1:0]  op;
    logic [7:0]  addr;
    logic [15:0] data;
    logic [15:0] mask;
  } cmd_t;
  typedef enum logic [2:0] {IDLE, BUS, WRB, GAP, RESP} state_t;
  cmd_t          fifo [FIFO_DEPTH];
  cmd_t          cmd, head;
  state_t        state;
  logic [AW:0]   wp, rp;
  logic [CW-1:0] cnt;
  logic [GW-1:0] gcnt;
  logic          full, empty, push, pop, match, last;
  logic [15:0]   rmw_val;
  assign full      = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
  assign empty     = wp == rp;
  assign req_ready = !full;
  assign push      = req_valid && !full;
  assign pop       = state == IDLE && !empty;
  assign head      = fifo[rp[AW-1:0]];
  assign rmw_val   = (sfr_data & ~cmd.mask) | (cmd.data & cmd.mask);
  assign match     = ((sfr_data ^ cmd.data) & cmd.mask) == 16'h0;
  assign last      = cnt == CW'(POLL_MAX - 1);
  always_ff @(posedge clk)
    if (push) fifo[wp[AW-1:0]] <= '{req_op, req_addr, req_data, req_mask};
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state     <= IDLE;
      wp        <= '0;
      rp        <= '0;
      cmd       <= '0;
      cnt       <= '0;
      gcnt      <= '0;
      sel       <= 1'b0;
      r         <= 1'b0;
      w         <= 2'b00;
      addr      <= 8'h00;
      dwrite    <= 16'h0;
      rsp_valid <= 1'b0;
      rsp_data  <= 16'h0;
      rsp_err   <= 1'b0;
    end else begin
      if (push) wp <= wp + 1'b1;
      sel    <= 1'b0;
      r      <= 1'b0;
      w      <= 2'b00;
      dwrite <= 16'h0;
      case (state)
        IDLE: if (pop) begin
          rp     <= rp + 1'b1;
          cmd    <= head;
          cnt    <= '0;
          sel    <= 1'b1;
          addr   <= head.addr;
          r      <= head.op != OP_WR;
          w      <= head.op == OP_WR ? head.mask[1:0] : 2'b00;
          dwrite <= head.op == OP_WR ? head.data : 16'h0;
          state  <= BUS;
        end
        BUS: case (cmd.op)
          OP_WR, OP_RD: begin
            rsp_data  <= cmd.op == OP_WR ? cmd.data : sfr_data;
            rsp_err   <= 1'b0;
            rsp_valid <= 1'b1;
            state     <= RESP;
          end
          OP_RMW: begin
            sel      <= 1'b1;
            w        <= 2'b11;
            dwrite   <= rmw_val;
            rsp_data <= rmw_val;
            state    <= WRB;
          end
          default: begin
            rsp_data <= sfr_data;
            cnt      <= cnt + 1'b1;
            if (match || last) begin
              rsp_err   <= !match;
              rsp_valid <= 1'b1;
              state     <= RESP;
            end else if (POLL_GAP == 0) begin
              sel <= 1'b1;
              r   <= 1'b1;
            end else begin
              gcnt  <= '0;
              state <= GAP;
            end
          end
        endcase
        WRB: begin
          rsp_err   <= 1'b0;
          rsp_valid <= 1'b1;
          state     <= RESP;
        end
        GAP: if (gcnt == GW'(POLL_GAP - 1)) begin
          sel   <= 1'b1;
          r     <= 1'b1;
          state <= BUS;
        end else gcnt <= gcnt + 1'b1;
        RESP: if (rsp_ready) begin
          rsp_valid <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_sfr_master.sv
// tb_sfr_master: directed checks of sfr_master bus timing, responses, backpressure and reset
module tb_sfr_master;
  logic        clk = 0, nreset = 0;
  logic        req_valid = 0, req_ready, rsp_valid, rsp_ready = 1, rsp_err, sel, r;
  logic [1:0]  req_op = 0, w;
  logic [7:0]  req_addr = 0, addr;
  logic [15:0] req_data = 0, req_mask = 0, rsp_data, dwrite, sfr_data;
  int          tests = 0, fails = 0, cyc = 0, nb = 0, pcnt = 0, pbase = 0;
  logic [15:0] smem [256];
  bit          wv [256];
  int          lcyc [256];
  logic [26:0] lbus [256];

  sfr_master #(.FIFO_DEPTH(4), .POLL_MAX(8), .POLL_GAP(3)) dut (
    .clk(clk), .nreset(nreset), .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_addr(req_addr), .req_data(req_data), .req_mask(req_mask),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .sel(sel), .addr(addr), .r(r), .w(w), .dwrite(dwrite), .sfr_data(sfr_data));

  always #5 clk = ~clk;

  function automatic logic [15:0] dflt(input logic [7:0] a);
    return a == 8'h16 ? 16'hBEEF : a == 8'h24 ? 16'h00F0 : {a, ~a};
  endfunction
  function automatic logic [15:0] cur(input logic [7:0] a);
    return wv[a] ? smem[a] : dflt(a);
  endfunction

  // Responder model: address 0x40 reports bit0 set from the 4th read after pbase.
  assign sfr_data = addr == 8'h40 ? {15'd0, (pcnt - pbase) >= 3} : cur(addr);
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (sel && r && addr == 8'h40) pcnt <= pcnt + 1;
  end
  always @(negedge clk) if (sel) begin
    if (|w) begin
      smem[addr] <= {w[1] ? dwrite[15:8] : cur(addr)[15:8], w[0] ? dwrite[7:0] : cur(addr)[7:0]};
      wv[addr]   <= 1'b1;
    end
    lcyc[nb] <= cyc;
    lbus[nb] <= {addr, r, w, dwrite};
    nb       <= nb + 1;
  end

  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    tests++;
    assert (o === e) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, o, e);
    end
  endtask

  task automatic send(input logic [1:0] op, input logic [7:0] a, input logic [15:0] d,
                      input logic [15:0] m, output int acc);
    req_valid = 1; req_op = op; req_addr = a; req_data = d; req_mask = m; acc = -1;
    for (int i = 0; i < 20; i++) begin
      if (req_ready) begin
        acc = cyc;
        @(posedge clk); #1;
        break;
      end
      @(posedge clk); #1;
    end
    req_valid = 0;
  endtask

  task automatic wait_rsp(output int c, output logic [15:0] d, output logic e);
    int n = 0;
    c = -1; d = 'x; e = 'x;
    do begin @(negedge clk); n++; end while (!rsp_valid && n < 2000);
    if (rsp_valid) begin c = cyc; d = rsp_data; e = rsp_err; end
    @(posedge clk); #1;
  endtask

  initial begin
    int a, b, c, n0, nacc;
    logic [15:0] d;
    logic e;
    #1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_bus", {sel, r, w, addr, dwrite}, 0);
    chk("rst_rsp", {rsp_valid, rsp_err, rsp_data}, 0);
    chk("rst_ready", req_ready, 1);
    nreset = 1;
    @(posedge clk); #1;
    // WRITE full word
    n0 = nb;
    send(2'b00, 8'h00, 16'h1234, 16'h0003, a);
    wait_rsp(c, d, e);
    chk("wr_ncyc", nb - n0, 1);
    chk("wr_buscyc", lcyc[n0], a + 2);
    chk("wr_bus", lbus[n0], {8'h00, 1'b0, 2'b11, 16'h1234});
    chk("wr_rspcyc", c, a + 3);
    chk("wr_rsp", {e, d}, {1'b0, 16'h1234});
    // WRITE low byte only
    n0 = nb;
    send(2'b00, 8'h00, 16'hABCD, 16'hFFF1, a);
    wait_rsp(c, d, e);
    chk("wrbe_bus", lbus[n0], {8'h00, 1'b0, 2'b01, 16'hABCD});
    chk("wrbe_mem", cur(8'h00), 16'h12CD);
    // READ
    n0 = nb;
    send(2'b01, 8'h16, 16'h0, 16'h0, a);
    wait_rsp(c, d, e);
    chk("rd_ncyc", nb - n0, 1);
    chk("rd_buscyc", lcyc[n0], a + 2);
    chk("rd_bus", lbus[n0], {8'h16, 1'b1, 2'b00, 16'h0});
    chk("rd_rspcyc", c, a + 3);
    chk("rd_rsp", {e, d}, {1'b0, 16'hBEEF});
    // RMW: (00F0 & ~0F0F) | (0505 & 0F0F) = 05F5
    n0 = nb;
    send(2'b10, 8'h24, 16'h0505, 16'h0F0F, a);
    wait_rsp(c, d, e);
    chk("rmw_ncyc", nb - n0, 2);
    chk("rmw_rdcyc", lcyc[n0], a + 2);
    chk("rmw_rd", lbus[n0], {8'h24, 1'b1, 2'b00, 16'h0});
    chk("rmw_wrcyc", lcyc[n0 + 1], a + 3);
    chk("rmw_wr", lbus[n0 + 1], {8'h24, 1'b0, 2'b11, 16'h05F5});
    chk("rmw_rspcyc", c, a + 4);
    chk("rmw_rsp", {e, d}, {1'b0, 16'h05F5});
    chk("rmw_mem", cur(8'h24), 16'h05F5);
    // POLL matching on the 4th read
    n0 = nb;
    pbase = pcnt;
    send(2'b11, 8'h40, 16'h0001, 16'h0001, a);
    wait_rsp(c, d, e);
    chk("poll_ncyc", nb - n0, 4);
    for (int i = 0; i < 4; i++) chk("poll_cyc", lcyc[n0 + i], a + 2 + 4 * i);
    chk("poll_bus", lbus[n0 + 3], {8'h40, 1'b1, 2'b00, 16'h0});
    chk("poll_rspcyc", c, a + 15);
    chk("poll_rsp", {e, d}, {1'b0, 16'h0001});
    // POLL never matching: POLL_MAX reads then timeout
    n0 = nb;
    send(2'b11, 8'h50, 16'h0001, 16'hFFFF, a);
    wait_rsp(c, d, e);
    chk("pto_ncyc", nb - n0, 8);
    chk("pto_lastcyc", lcyc[n0 + 7], a + 30);
    chk("pto_rspcyc", c, a + 31);
    chk("pto_rsp", {e, d}, {1'b1, 16'h50AF});
    send(2'b01, 8'h16, 16'h0, 16'h0, a);
    wait_rsp(c, d, e);
    chk("errclr_rsp", {e, d}, {1'b0, 16'hBEEF});
    // Backpressure: one command in RESP plus four queued
    n0 = nb;
    nacc = 0;
    rsp_ready = 0;
    for (int i = 0; i < 6; i++) begin
      send(2'b01, 8'h60 + 8'(i), 16'h0, 16'h0, a);
      if (a >= 0) nacc++;
    end
    chk("bp_accepted", nacc, 5);
    chk("bp_ready", req_ready, 0);
    chk("bp_ncyc", nb - n0, 1);
    chk("bp_hold", {rsp_valid, rsp_data}, {1'b1, dflt(8'h60)});
    rsp_ready = 1;
    for (int i = 0; i < 5; i++) begin
      wait_rsp(c, d, e);
      chk("bp_order", {e, d}, {1'b0, dflt(8'h60 + 8'(i))});
    end
    chk("bp_total", nb - n0, 5);
    // Reset during POLL gap with a READ queued
    n0 = nb;
    send(2'b11, 8'h50, 16'h0001, 16'hFFFF, a);
    send(2'b01, 8'h60, 16'h0, 16'h0, b);
    while (cyc < a + 4) @(negedge clk);
    nreset = 0;
    #1;
    chk("rstop_bus", {sel, r, w, addr, dwrite}, 0);
    chk("rstop_rsp", {rsp_valid, rsp_err}, 0);
    chk("rstop_ready", req_ready, 1);
    chk("rstop_ncyc", nb - n0, 1);
    @(negedge clk);
    nreset = 1;
    repeat (10) @(posedge clk);
    #1;
    chk("rstop_empty", nb - n0, 1);
    chk("rstop_after", {rsp_valid, req_ready}, 2'b01);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
